ann_neuron_mac: RTL and testbench

//  Consumer stage for one neuron's weight BRAM. Sequences W_ADDR 0..N_IN-1 into the weight

---
 rtl/ann_pkg.sv | 16 +
 rtl/ann_sat_round.sv | 32 +++
 rtl/ann_neuron_mac.sv | 160 ++++++++++++++++
 tb/tb_ann_neuron_mac.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared definitions for the neuron layers: FSM state encoding and Q8.8 constants.
package ann_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ann_state_e;

    localparam int                 Q_FRAC       = 8;
    localparam logic signed [15:0] Q_MAX        = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN        = 16'sh8000;
    localparam int                 N_IN_DEFAULT = 28;

endpackage

// File: rtl/ann_sat_round.sv
// Accumulator-to-output conversion: drops FRAC fractional bits with an arithmetic
// shift (floor toward -inf) and clamps the result into a signed DW-bit word.
// Purely combinational so later layers can reuse it in front of their own registers.
module ann_sat_round
    import ann_pkg::*;
#(
    parameter int DW    = 16,
    parameter int FRAC  = Q_FRAC,
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [DW-1:0]    y_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted_s;

    // Floor-shift the accumulator and clamp it to the representable output range.
    always_comb begin
        shifted_s = acc_i >>> FRAC;
        if (shifted_s > SAT_MAX) begin
            y_o = SAT_MAX[DW-1:0];
        end else if (shifted_s < SAT_MIN) begin
            y_o = SAT_MIN[DW-1:0];
        end else begin
            y_o = shifted_s[DW-1:0];
        end
    end

endmodule

// File: rtl/ann_neuron_mac.sv
// One neuron: walks the weight BRAM, multiplies each weight with a streamed
// activation, accumulates, adds the bias, saturates to Q8.8 and hands the result
// downstream on a valid/ready handshake.
// Optional feature: define ANN_NEURON_RELU_EN to clamp negative outputs to zero
// inside the output register (no extra latency).
module ann_neuron_mac
    import ann_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int DW    = 16,
    parameter int FRAC  = Q_FRAC,
    parameter int AW    = 5,
    parameter int ACC_W = 40
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [DW-1:0] BIAS,
    input  logic [DW-1:0] X_DATA,
    input  logic          X_VALID,
    output logic          X_READY,
    output logic [AW-1:0] W_ADDR,
    output logic          W_EN,
    output logic          W_WE,
    input  logic [DW-1:0] W_DO,
    output logic [DW-1:0] Y_DATA,
    output logic          Y_VALID,
    input  logic          Y_READY,
    output logic          BUSY
);

    ann_state_e              state_q,    state_d;
    logic [AW-1:0]           idx_q,      idx_d;
    logic signed [DW-1:0]    bias_q,     bias_d;
    logic signed [2*DW-1:0]  prod_q,     prod_d;
    logic                    prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0] acc_q,      acc_d;
    logic [DW-1:0]           y_data_q,   y_data_d;
    logic                    y_valid_q,  y_valid_d;

    logic                    fire_s;
    logic signed [2*DW-1:0]  mult_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] acc_sum_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic signed [ACC_W-1:0] pre_sat_s;
    logic signed [DW-1:0]    sat_s;
    logic [DW-1:0]           y_next_s;

    assign fire_s     = X_VALID && (state_q == ST_RUN);
    assign mult_s     = $signed(X_DATA) * $signed(W_DO);
    assign prod_ext_s = {{(ACC_W-2*DW){prod_q[2*DW-1]}}, prod_q};
    // The product lands in the accumulator one cycle after its fire.
    assign acc_sum_s  = acc_q + (prod_vld_q ? prod_ext_s : {ACC_W{1'b0}});
    // Bias aligned to the Q16.16 product scale.
    assign bias_ext_s = {{(ACC_W-DW-FRAC){bias_q[DW-1]}}, bias_q, {FRAC{1'b0}}};
    assign pre_sat_s  = acc_sum_s + bias_ext_s;

    ann_sat_round #(
        .DW    (DW),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_sat (
        .acc_i (pre_sat_s),
        .y_o   (sat_s)
    );

`ifdef ANN_NEURON_RELU_EN
    assign y_next_s = sat_s[DW-1] ? {DW{1'b0}} : sat_s;
`else
    assign y_next_s = sat_s;
`endif

    // Next-state logic for the sequencing FSM, index counter and datapath registers.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bias_d     = bias_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_sum_s;
        y_data_d   = y_data_q;
        y_valid_d  = y_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    idx_d   = {AW{1'b0}};
                    bias_d  = BIAS;
                    acc_d   = {ACC_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fire_s) begin
                    prod_d     = mult_s;
                    prod_vld_d = 1'b1;
                    if (idx_q == AW'(N_IN - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Final product is folded straight into the output register.
                y_data_d  = y_next_s;
                y_valid_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (Y_READY) begin
                    y_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                y_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= {AW{1'b0}};
            bias_q     <= {DW{1'b0}};
            prod_q     <= {(2*DW){1'b0}};
            prod_vld_q <= 1'b0;
            acc_q      <= {ACC_W{1'b0}};
            y_data_q   <= {DW{1'b0}};
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bias_q     <= bias_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            y_data_q   <= y_data_d;
            y_valid_q  <= y_valid_d;
        end
    end

    assign X_READY = (state_q == ST_RUN);
    assign W_EN    = (state_q == ST_RUN);
    assign W_ADDR  = idx_q;
    assign W_WE    = 1'b0;
    assign BUSY    = (state_q != ST_IDLE);
    assign Y_DATA  = y_data_q;
    assign Y_VALID = y_valid_q;

endmodule

// File: tb/tb_ann_neuron_mac.sv
// Self-checking bench for ann_neuron_mac: a transaction-level reference model
// (fire counting, plain integer dot product, floor/saturate) checked every cycle,
// plus hand-computed literal results for each directed scenario.
module tb_ann_neuron_mac;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] BIAS = 16'h0000;
    logic [15:0] X_DATA = 16'h0000;
    logic        X_VALID = 1'b0;
    logic        X_READY;
    logic [4:0]  W_ADDR;
    logic        W_EN;
    logic        W_WE;
    logic [15:0] W_DO = 16'h0000;
    logic [15:0] Y_DATA;
    logic        Y_VALID;
    logic        Y_READY = 1'b1;
    logic        BUSY;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] w_mem [0:31];
    logic [15:0] x_mem [0:31];

    ann_neuron_mac dut (
        .CLK(CLK), .RST(RST), .START(START), .BIAS(BIAS),
        .X_DATA(X_DATA), .X_VALID(X_VALID), .X_READY(X_READY),
        .W_ADDR(W_ADDR), .W_EN(W_EN), .W_WE(W_WE), .W_DO(W_DO),
        .Y_DATA(Y_DATA), .Y_VALID(Y_VALID), .Y_READY(Y_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Weight BRAM: read on the falling edge while enabled.
    always @(negedge CLK) begin
        if (W_EN) W_DO <= w_mem[W_ADDR];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected neuron output from the plain arithmetic rules.
    function automatic logic [15:0] model_y(input longint s, input shortint b);
        longint v;
        v = (s + longint'(b) * 64'sd256) >>> 8;
        if (v > 64'sd32767) v = 64'sd32767;
        else if (v < -64'sd32768) v = -64'sd32768;
`ifdef ANN_NEURON_RELU_EN
        if (v < 64'sd0) v = 64'sd0;
`endif
        return v[15:0];
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 collecting activations, 2 finishing, 3 result offered
    int          m_phase = 0;
    int          m_cnt = 0;
    longint      m_sum = 0;
    shortint     m_bias = 0;
    logic [15:0] exp_ydata = 16'h0000;
    bit          exp_yvalid = 1'b0;
    bit          exp_rst = 1'b0;
    bit          model_ok = 1'b0;

    always @(posedge CLK) begin
        model_ok <= 1'b1;
        exp_rst  <= 1'b0;
        if (RST) begin
            m_phase    <= 0;
            m_cnt      <= 0;
            m_sum      <= 0;
            exp_ydata  <= 16'h0000;
            exp_yvalid <= 1'b0;
            exp_rst    <= 1'b1;
        end else begin
            case (m_phase)
                0: if (START) begin
                    m_phase <= 1;
                    m_cnt   <= 0;
                    m_sum   <= 0;
                    m_bias  <= shortint'($signed(BIAS));
                end
                1: if (X_VALID) begin
                    m_sum <= m_sum + longint'($signed(X_DATA)) * longint'($signed(w_mem[m_cnt]));
                    if (m_cnt == 27) m_phase <= 2;
                    else m_cnt <= m_cnt + 1;
                end
                2: begin
                    m_phase    <= 3;
                    exp_yvalid <= 1'b1;
                    exp_ydata  <= model_y(m_sum, m_bias);
                end
                3: if (Y_READY) begin
                    m_phase    <= 0;
                    exp_yvalid <= 1'b0;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge CLK) begin
        if (model_ok) begin
            chk("x_ready", 32'(X_READY), 32'(m_phase == 1));
            chk("w_en",    32'(W_EN),    32'(m_phase == 1));
            chk("w_we",    32'(W_WE),    32'd0);
            chk("busy",    32'(BUSY),    32'(m_phase != 0));
            chk("y_valid", 32'(Y_VALID), 32'(exp_yvalid));
            chk("w_addr_max", 32'(W_ADDR <= 5'd27), 32'd1);
            if (m_phase == 1 || exp_rst) chk("w_addr", 32'(W_ADDR), m_cnt);
            if (exp_yvalid || exp_rst)   chk("y_data", 32'(Y_DATA), 32'(exp_ydata));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < 32; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    task automatic start(input logic [15:0] b);
        int g = 0;
        while (BUSY && g < 200) begin
            @(posedge CLK); #1;
            g++;
        end
        if (BUSY) begin
            bad++;
            $display("FAIL idle_timeout busy=%0d expected=0", BUSY);
        end
        START = 1'b1;
        BIAS  = b;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic feed(input bit rnd, input int stop_at, output int last_cyc);
        int n = 0;
        int g = 0;
        last_cyc = 0;
        while (n < stop_at && g < 1000) begin
            X_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            X_DATA  = x_mem[n];
            @(negedge CLK);
            if (X_VALID && X_READY) begin
                n++;
                last_cyc = cyc;
            end
            @(posedge CLK); #1;
            g++;
        end
        X_VALID = 1'b0;
        if (n < stop_at) begin
            bad++;
            $display("FAIL feed_timeout fires=%0d expected=%0d", n, stop_at);
        end
    endtask

    task automatic wait_y(output logic [15:0] y, output int vcyc);
        int g = 0;
        y = 16'hxxxx;
        vcyc = 0;
        @(negedge CLK);
        while (!Y_VALID && g < 100) begin
            @(negedge CLK);
            g++;
        end
        total++;
        if (!Y_VALID) begin
            bad++;
            $display("FAIL y_valid_timeout y_valid=0 expected=1");
        end else begin
            y = Y_DATA;
            vcyc = cyc;
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [15:0] y;
        int lf, vc;

        load(16'h0100, 16'h0100);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_y_data",  32'(Y_DATA),  32'h0);
        chk("rst_w_addr",  32'(W_ADDR),  32'h0);
        chk("rst_busy",    32'(BUSY),    32'h0);
        @(posedge CLK); #1;

        // 1: 28 x (1.0*1.0) = 28.0, result two cycles after last fire
        load(16'h0100, 16'h0100);
        start(16'h0000);
        feed(1'b0, 28, lf);
        wait_y(y, vc);
        chk("t1_y", 32'(y), 32'h1C00);
        chk("t1_latency", vc - lf, 32'd2);
        chk("t1_model", 32'(model_y(64'sd1835008, 16'sd0)), 32'h1C00);
        @(posedge CLK); #1;

        // 2: positive saturation
        load(16'h7FFF, 16'h7FFF);
        start(16'h0000);
        feed(1'b0, 28, lf);
        wait_y(y, vc);
        chk("t2_y", 32'(y), 32'h7FFF);
        @(posedge CLK); #1;

        // 3: 28 x (-1.0) + 2.0 = -26.0
        load(16'hFF00, 16'h0100);
        start(16'h0200);
        feed(1'b0, 28, lf);
        wait_y(y, vc);
`ifdef ANN_NEURON_RELU_EN
        chk("t3_y", 32'(y), 32'h0000);
`else
        chk("t3_y", 32'(y), 32'hE600);
`endif
        @(posedge CLK); #1;

        // 4: 50% activation duty, same data as test 1
        load(16'h0100, 16'h0100);
        start(16'h0000);
        feed(1'b1, 28, lf);
        wait_y(y, vc);
        chk("t4_y", 32'(y), 32'h1C00);
        chk("t4_latency", vc - lf, 32'd2);
        @(posedge CLK); #1;

        // 5: reset after 10 fires, then a clean run
        start(16'h0000);
        feed(1'b0, 10, lf);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("t5_x_ready", 32'(X_READY), 32'h0);
        chk("t5_w_en",    32'(W_EN),    32'h0);
        chk("t5_w_addr",  32'(W_ADDR),  32'h0);
        chk("t5_y_valid", 32'(Y_VALID), 32'h0);
        chk("t5_y_data",  32'(Y_DATA),  32'h0);
        chk("t5_busy",    32'(BUSY),    32'h0);
        @(posedge CLK); #1;
        start(16'h0000);
        feed(1'b0, 28, lf);
        wait_y(y, vc);
        chk("t5_y", 32'(y), 32'h1C00);
        @(posedge CLK); #1;

        // 6: downstream stalls 20 cycles; START and X_VALID must be ignored
        Y_READY = 1'b0;
        start(16'h0000);
        feed(1'b0, 28, lf);
        wait_y(y, vc);
        chk("t6_y", 32'(y), 32'h1C00);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            START   = (i % 5 == 0);
            X_VALID = 1'b1;
            @(negedge CLK);
            chk("t6_hold_data",  32'(Y_DATA),  32'(y));
            chk("t6_hold_valid", 32'(Y_VALID), 32'h1);
        end
        START   = 1'b0;
        X_VALID = 1'b0;
        Y_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_y_valid_drop", 32'(Y_VALID), 32'h0);
        chk("t6_busy_drop",    32'(BUSY),    32'h0);
        repeat (3) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
